// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: one-block-at-a-time SHA-256 compression controller.
// Accepts a padded 512-bit block, runs 64 rounds (one per cycle) with the
// message schedule generated in a rolling 16-word window, then folds the
// working variables into the chain value H.
// Optional feature: define SHA256_BLOCK_CTRL_ABORT_EN to add an abort input.
module sha256_block_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA256_BLOCK_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_e;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [31:0]  work_q [8];
  logic [31:0]  work_d [8];
  logic [31:0]  h_q [8];
  logic [31:0]  h_d [8];
  logic [511:0] blk_q, blk_d;
  logic         first_q, first_d;
  logic         last_q, last_d;
  logic         dv_q, dv_d;
  logic         abort_req;

  logic [31:0]  bs0, bs1, ch, maj, t1, t2, w_new;

`ifdef SHA256_BLOCK_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Round function and schedule expansion from the current registers.
  // The window holds W[t..t+15]; w_new is W[t+16], shifted in each round.
  always_comb begin
    bs1   = rotr(work_q[4], 6) ^ rotr(work_q[4], 11) ^ rotr(work_q[4], 25);
    ch    = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
    t1    = work_q[7] + bs1 + ch + K[t_q] + w_q[0];
    bs0   = rotr(work_q[0], 2) ^ rotr(work_q[0], 13) ^ rotr(work_q[0], 22);
    maj   = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
    t2    = bs0 + maj;
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
  end

  // Next-state and datapath update for the block FSM.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    work_d  = work_q;
    h_d     = h_q;
    blk_d   = blk_q;
    first_d = first_q;
    last_d  = last_q;
    dv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (blk_valid) begin
          blk_d   = blk_data;
          first_d = blk_first;
          last_d  = blk_last;
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int unsigned i = 0; i < 16; i++) w_d[i] = blk_q[32*(15-i) +: 32];
        for (int unsigned i = 0; i < 8; i++)  work_d[i] = first_q ? IV[i] : h_q[i];
        t_d     = '0;
        state_d = ROUND;
      end
      ROUND: begin
        for (int unsigned i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15]   = w_new;
        work_d[7] = work_q[6];
        work_d[6] = work_q[5];
        work_d[5] = work_q[4];
        work_d[4] = work_q[3] + t1;
        work_d[3] = work_q[2];
        work_d[2] = work_q[1];
        work_d[1] = work_q[0];
        work_d[0] = t1 + t2;
        if (t_q == 6'd63) state_d = UPDATE;
        else              t_d = t_q + 6'd1;
      end
      UPDATE: begin
        for (int unsigned i = 0; i < 8; i++) h_d[i] = (first_q ? IV[i] : h_q[i]) + work_q[i];
        dv_d    = last_q;
        state_d = IDLE;
      end
    endcase
    // Abort overrides the case result: chain value and pulse are held back.
    if (abort_req && (state_q != IDLE)) begin
      state_d = IDLE;
      h_d     = h_q;
      dv_d    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: round counter, schedule window, working vars, chain value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        work_q[i] <= '0;
        h_q[i]    <= IV[i];
      end
      blk_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      t_q     <= t_d;
      w_q     <= w_d;
      work_q  <= work_d;
      h_q     <= h_d;
      blk_q   <= blk_d;
      first_q <= first_d;
      last_q  <= last_d;
      dv_q    <= dv_d;
    end
  end

  assign blk_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign digest_valid = dv_q;
  assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: doc/sha256_block_ctrl.md
SHA256_BLOCK_CTRL -- requirements
Module: sha256_block_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; its ports SHALL be as follows (clock and reset first):
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous active-low reset
- blk_valid  in  1  a 512-bit message block is offered
- blk_ready  out  1  controller can accept a block
- blk_data  in  512  padded block; word 0 = bits [511:480]
- blk_first  in  1  block starts a new message; chain value reloads from IV
- blk_last  in  1  block ends a message; digest is reported
- busy  out  1  block in progress
- digest_valid  out  1  one-cycle pulse; digest is final
- digest  out  256  chain value H0..H7; H0 = bits [255:224]

Function
REQ-002 FSM states SHALL be IDLE, LOAD, ROUND and UPDATE; blk_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in every other state.
- Handshake: a block is accepted on a rising edge with blk_valid=1 and blk_ready=1.
- blk_data, blk_first and blk_last SHALL be captured on that edge; the state goes IDLE->LOAD.
REQ-003 LOAD (1 cycle):
- Fill the 16-word schedule window with W0..W15 from the captured block.
- Load working registers a..h from IV if blk_first=1, otherwise from H.
- Go to ROUND with round counter t=0.
REQ-004 ROUND (64 cycles, t=0..63): each cycle performs one SHA-256 compression round using K[t] and W[t].
- For t>=16, W[t] = W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]), all mod 2^32.
- s0 = rotr7 ^ rotr18 ^ shr3; s1 = rotr17 ^ rotr19 ^ shr10.
- W[t] is generated in the rolling 16-word window, one word per cycle; the full 64-word expansion is never stored.
REQ-005 At t=63 the FSM SHALL go ROUND->UPDATE, and the counter SHALL NOT wrap into a 65th round.
REQ-006 UPDATE (1 cycle) SHALL set Hi <= Hbase_i + working_i mod 2^32, where Hbase is IV if the captured blk_first=1, else H. The FSM then returns to IDLE.
REQ-007 digest_valid SHALL pulse high for exactly one cycle, on the edge that leaves UPDATE, only if the captured blk_last=1.
- Accept-to-pulse latency SHALL be exactly 66 clock edges.
- A new block can be accepted on the edge 67 after the previous accept.
REQ-008 digest SHALL be driven continuously from H and SHALL change only on the UPDATE edge.
REQ-009 blk_valid while blk_ready=0 SHALL be ignored with no side effects; the source must hold it.
REQ-010 blk_first=1 together with blk_last=1 SHALL be treated as a single-block message.
REQ-011 A block with blk_first=0 after power-up SHALL chain from the reset value of H, which is IV.

Reset
REQ-012 While rst_n=0, and immediately when it asserts:
- State = IDLE, t = 0, schedule window = 0, a..h = 0, H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
- Outputs: blk_ready=1, busy=0, digest_valid=0, digest=IV.
REQ-013 Reset asserted mid-block SHALL abandon the block: no digest_valid is produced and H stays at IV.

Configuration
REQ-014 With SHA256_BLOCK_CTRL_ABORT_EN defined, the block SHALL add a 1-bit input abort.
- abort=1 in LOAD, ROUND or UPDATE returns the FSM to IDLE on the next edge.
- H is left unchanged (an abort in UPDATE suppresses the H write) and no digest_valid is produced.
- abort in IDLE SHALL have no effect.
REQ-015 Without SHA256_BLOCK_CTRL_ABORT_EN, the abort port and its logic SHALL be absent and every block SHALL run to completion.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Block 61626380, 13 zero words, 00000018, first=last=1 -> digest_valid 66 edges after accept; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Block 80000000 followed by 15 zero words, first=last=1 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first on block 1, last on block 2), sent back-to-back -> no pulse after block 1; one pulse after block 2 with digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- blk_valid held high throughout a block -> second accept occurs exactly when blk_ready returns; no extra accept.
- rst_n pulsed low at round 30 -> all outputs at reset values, no pulse; a subsequent "abc" block gives the correct digest.
- With SHA256_BLOCK_CTRL_ABORT_EN, abort at round 10 of the second "abc" block -> IDLE next cycle, digest still ba7816bf..., no pulse.
